// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with sign fix-up at the end.
module mdu_iterative #(
  parameter int MDU_OP_WIDTH = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [MDU_OP_WIDTH-1:0] op_i,
  input  logic [31:0]             op_a_i,
  input  logic [31:0]             op_b_i,
  input  logic                    kill_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [31:0]             result_o
);

  // state | meaning
  // IDLE  | waiting for start_i; operands latched on acceptance
  // PREP  | magnitudes/signs computed, accumulator cleared, div special cases resolved
  // CALC  | 32 iterations, one product/quotient bit per cycle
  // FIN   | sign correction, result_o registered, done_o pulsed

  localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = MDU_OP_WIDTH'(0);
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = MDU_OP_WIDTH'(1);
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = MDU_OP_WIDTH'(2);
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = MDU_OP_WIDTH'(3);
  localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = MDU_OP_WIDTH'(4);
  localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = MDU_OP_WIDTH'(5);
  localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = MDU_OP_WIDTH'(6);
  localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = MDU_OP_WIDTH'(7);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

  state_t                  state;
  logic [MDU_OP_WIDTH-1:0] op_q;
  logic [31:0]             a_q, b_q;
  logic [31:0]             mag_a, mag_b;
  logic                    neg_q, neg_r, bypass;
  logic [63:0]             acc;
  logic [4:0]              cnt;

  logic        a_signed, b_signed, is_div, is_rem;
  logic        a_neg, b_neg, div_zero, div_ovf;
  logic [31:0] a_mag, b_mag, special_res;

  assign a_signed = op_q inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  assign b_signed = op_q inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  assign is_div   = op_q inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  assign is_rem   = op_q inside {MDU_REM, MDU_REMU};

  assign a_neg    = a_signed & a_q[31];
  assign b_neg    = b_signed & b_q[31];
  assign a_mag    = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag    = b_neg ? (~b_q + 32'd1) : b_q;
  assign div_zero = is_div && (b_q == 32'd0);
  assign div_ovf  = (op_q inside {MDU_DIV, MDU_REM}) &&
                    (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

  always_comb begin
    special_res = 32'd0;
    if (div_zero)
      special_res = is_rem ? a_q : 32'hFFFF_FFFF;
    else if (div_ovf)
      special_res = is_rem ? 32'd0 : 32'h8000_0000;
  end

  // Multiply: upper half accumulates, the whole accumulator shifts right each step.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, acc[63:32]} + (mag_b[cnt] ? {1'b0, mag_a} : 33'd0);

  // Divide: partial remainder in acc[63:32], quotient bits shift into acc[31:0].
  logic [32:0] rem_sh;
  logic [31:0] rem_sub, rem_nx;
  logic        rem_ge;
  assign rem_sh  = {acc[63:32], mag_a[~cnt]};
  assign rem_ge  = rem_sh >= {1'b0, mag_b};
  assign rem_sub = rem_sh[31:0] - mag_b;
  assign rem_nx  = rem_ge ? rem_sub : rem_sh[31:0];

  logic [63:0] prod;
  logic [31:0] quo, remd, fin_res;
  assign prod = neg_q ? (~acc + 64'd1) : acc;
  assign quo  = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign remd = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];

  always_comb begin
    fin_res = prod[63:32];
    if (bypass)
      fin_res = acc[31:0];
    else if (is_rem)
      fin_res = remd;
    else if (is_div)
      fin_res = quo;
    else if (op_q == MDU_MUL)
      fin_res = prod[31:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      bypass   <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !kill_i) begin
            op_q   <= op_i;
            a_q    <= op_a_i;
            b_q    <= op_b_i;
            busy_o <= 1'b1;
            state  <= PREP;
          end
        end
        PREP: begin
          if (kill_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            mag_a <= a_mag;
            mag_b <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            cnt   <= '0;
            if (div_zero || div_ovf) begin
              bypass <= 1'b1;
              acc    <= {32'd0, special_res};
              state  <= FIN;
            end else begin
              bypass <= 1'b0;
              acc    <= '0;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (kill_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            acc <= is_div ? {rem_nx, acc[30:0], rem_ge} : {mul_sum, acc[31:1]};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31)
              state <= FIN;
          end
        end
        FIN: begin
          busy_o <= 1'b0;
          state  <= IDLE;
          if (!kill_i) begin
            result_o <= fin_res;
            done_o   <= 1'b1;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
